// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_scoreboard_pkg;

    // Architectural register address width; the register count is 2**ADDR_WIDTH.
    localparam int ADDR_WIDTH = 4;

    // Register that is never tracked. Reads of it never stall.
    localparam int PC_REG_NUM = 15;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down counter of outstanding writes for one architectural register.
// Latency: count and nonzero update one cycle after inc/dec/clr.
// Backpressure: none; the caller must not raise inc at max unless dec is also raised.
//
// Ports:
//   clk_i, reset_n_i : clock and asynchronous active-low reset
//   inc, dec, clr    : increment, decrement, synchronous clear (clr wins)
//   count            : current outstanding-write count
//   nonzero          : count != 0
module sb_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 nonzero
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    // A decrement of an empty counter is dropped: stale writebacks are
    // legal after a flush and must neither underflow nor cancel an increment.
    logic dec_eff;
    assign dec_eff = dec && (count != CNT_ZERO);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count <= CNT_ZERO;
        end else if (clr) begin
            count <= CNT_ZERO;
        end else if (inc && !dec_eff) begin
            if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end else if (dec_eff && !inc) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = (count != CNT_ZERO);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding destination writes and stalls issue on RAW/saturation/drain.
// Latency: stall_o/issue_accept_o combinational; counters, busy_mask_o and drained_o one cycle after the event.
// Backpressure: stall_o blocks issue; drain_req_i blocks issue until every tracked write has retired.
//
// Optional feature macro SCOREBOARD_FWD_EN: when defined, a source whose only
// outstanding write is retiring this cycle is bypassed from writeback and does not stall.
//
// Ports:
//   clk_i, reset_n_i                      : clock, asynchronous active-low reset
//   issue_valid_i                         : decoded instruction presented for issue
//   reg_addr_{1,2}_i / reg_addr_{1,2}_valid_i : source addresses and use flags
//   reg_dest_addr_i / reg_dest_valid_i    : destination address and write flag
//   wb_valid_i / wb_addr_i                : one retiring register write per cycle
//   flush_i                               : squash everything in flight
//   drain_req_i                           : hold issue until all writes retire
//   stall_o, issue_accept_o               : issue blocked / issue taken this cycle
//   busy_mask_o                           : per-register outstanding-write flag
//   drained_o                             : drain complete
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 2 ** reg_scoreboard_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = 2,
    parameter int PC_REG_NUM = reg_scoreboard_pkg::PC_REG_NUM
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_1_i,
    input  logic                  reg_addr_1_valid_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_2_i,
    input  logic                  reg_addr_2_valid_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic                  reg_dest_valid_i,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic                  flush_i,
    input  logic                  drain_req_i,
    output logic                  stall_o,
    output logic                  issue_accept_o,
    output logic [NUM_REGS-1:0]   busy_mask_o,
    output logic                  drained_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR  = ADDR_WIDTH'(PC_REG_NUM);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    sb_state_t            state;
    logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  inc;
    logic [NUM_REGS-1:0]  dec;
    logic                 src1_haz;
    logic                 src2_haz;
    logic                 sat_haz;
    logic                 fwd1;
    logic                 fwd2;
    logic                 all_clear_next;

    // ---------------------------------------------------------------
    // Per-register counters
    // ---------------------------------------------------------------
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .clr       (flush_i),
            .count     (cnt[r]),
            .nonzero   (busy_mask_o[r])
        );
    end

    // ---------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------
`ifdef SCOREBOARD_FWD_EN
    // The last outstanding write retiring this cycle can be bypassed.
    assign fwd1 = wb_valid_i && (wb_addr_i == reg_addr_1_i) && (cnt[reg_addr_1_i] == CNT_ONE);
    assign fwd2 = wb_valid_i && (wb_addr_i == reg_addr_2_i) && (cnt[reg_addr_2_i] == CNT_ONE);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign src1_haz = reg_addr_1_valid_i && (reg_addr_1_i != PC_ADDR)
                   && (cnt[reg_addr_1_i] != CNT_ZERO) && !fwd1;
    assign src2_haz = reg_addr_2_valid_i && (reg_addr_2_i != PC_ADDR)
                   && (cnt[reg_addr_2_i] != CNT_ZERO) && !fwd2;

    // A full counter can still take an issue when a writeback to the same
    // register frees a slot in the same cycle (net count unchanged).
    assign sat_haz = reg_dest_valid_i && (reg_dest_addr_i != PC_ADDR)
                  && (cnt[reg_dest_addr_i] == CNT_MAX)
                  && !(wb_valid_i && (wb_addr_i == reg_dest_addr_i));

    assign stall_o        = issue_valid_i && (src1_haz || src2_haz || sat_haz || (state != SB_RUN));
    assign issue_accept_o = issue_valid_i && !stall_o && !flush_i;

    // ---------------------------------------------------------------
    // Counter update strobes; PC is never tracked
    // ---------------------------------------------------------------
    always_comb begin
        inc            = '0;
        dec            = '0;
        all_clear_next = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r] = issue_accept_o && reg_dest_valid_i && (reg_dest_addr_i != PC_ADDR)
                  && (reg_dest_addr_i == ADDR_WIDTH'(r));
            dec[r] = wb_valid_i && !flush_i && (wb_addr_i != PC_ADDR)
                  && (wb_addr_i == ADDR_WIDTH'(r));
            if (!((cnt[r] == CNT_ZERO) || ((cnt[r] == CNT_ONE) && dec[r]))) begin
                all_clear_next = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Drain FSM with registered drained_o
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= SB_RUN;
            drained_o <= 1'b0;
        end else if (flush_i) begin
            state     <= SB_RUN;
            drained_o <= 1'b0;
        end else begin
            case (state)
                SB_RUN: begin
                    drained_o <= 1'b0;
                    if (drain_req_i) begin
                        state <= SB_DRAIN;
                    end
                end
                SB_DRAIN: begin
                    if (!drain_req_i) begin
                        state     <= SB_RUN;
                        drained_o <= 1'b0;
                    end else if (all_clear_next) begin
                        state     <= SB_DONE;
                        drained_o <= 1'b1;
                    end
                end
                SB_DONE: begin
                    if (!drain_req_i) begin
                        state     <= SB_RUN;
                        drained_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= SB_RUN;
                    drained_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_reg_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        issue_valid;
    logic [3:0]  addr1;
    logic        addr1_vld;
    logic [3:0]  addr2;
    logic        addr2_vld;
    logic [3:0]  dest;
    logic        dest_vld;
    logic        wb_vld;
    logic [3:0]  wb_addr;
    logic        flush;
    logic        drain_req;
    logic        stall;
    logic        accept;
    logic [15:0] busy_mask;
    logic        drained;

    int checks = 0;
    int errors = 0;

    reg_scoreboard dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .issue_valid_i      (issue_valid),
        .reg_addr_1_i       (addr1),
        .reg_addr_1_valid_i (addr1_vld),
        .reg_addr_2_i       (addr2),
        .reg_addr_2_valid_i (addr2_vld),
        .reg_dest_addr_i    (dest),
        .reg_dest_valid_i   (dest_vld),
        .wb_valid_i         (wb_vld),
        .wb_addr_i          (wb_addr),
        .flush_i            (flush),
        .drain_req_i        (drain_req),
        .stall_o            (stall),
        .issue_accept_o     (accept),
        .busy_mask_o        (busy_mask),
        .drained_o          (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        addr1 = 4'd0; addr1_vld = 1'b0;
        addr2 = 4'd0; addr2_vld = 1'b0;
        dest  = 4'd0; dest_vld  = 1'b0;
        wb_vld = 1'b0; wb_addr = 4'd0;
        flush = 1'b0;
    endtask

    task automatic issue(input logic [3:0] d, input logic dv,
                         input logic [3:0] s1, input logic s1v,
                         input logic [3:0] s2, input logic s2v);
        issue_valid = 1'b1;
        dest = d;   dest_vld = dv;
        addr1 = s1; addr1_vld = s1v;
        addr2 = s2; addr2_vld = s2v;
    endtask

    task automatic wb(input logic [3:0] a);
        wb_vld  = 1'b1;
        wb_addr = a;
    endtask

    logic exp_fwd_stall;

    initial begin
`ifdef SCOREBOARD_FWD_EN
        exp_fwd_stall = 1'b0;
`else
        exp_fwd_stall = 1'b1;
`endif
        idle();
        drain_req = 1'b0;
        reset_n   = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", busy_mask, 16'h0000);
        chk("rst_drained", drained, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_accept", accept, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // RAW hazard on r3
        issue(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1 chk("raw_issue_acc", accept, 1'b1);
        tick();
        chk("raw_busy3", busy_mask, 16'h0008);
        idle();
        issue(4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0);
        #1 chk("raw_stall", stall, 1'b1);
        chk("raw_no_acc", accept, 1'b0);
        tick();
        wb(4'd3);
        #1 chk("raw_wb_cycle_stall", stall, exp_fwd_stall);
        tick();
        wb_vld = 1'b0;
        chk("raw_busy_clr", busy_mask, 16'h0000);
        #1 chk("raw_after_wb_stall", stall, 1'b0);
        chk("raw_after_wb_acc", accept, 1'b1);
        tick();
        idle();

        // Saturation on r2
        for (int i = 0; i < 3; i++) begin
            issue(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
            #1 chk("sat_fill_acc", accept, 1'b1);
            tick();
        end
        chk("sat_busy2", busy_mask, 16'h0004);
        #1 chk("sat_stall", stall, 1'b1);
        wb(4'd2);
        #1 chk("sat_wb_stall", stall, 1'b0);
        chk("sat_wb_acc", accept, 1'b1);
        tick();
        wb_vld = 1'b0;
        #1 chk("sat_still_full", stall, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            wb(4'd2);
            tick();
            chk("sat_drain_busy", busy_mask, (i == 2) ? 16'h0000 : 16'h0004);
        end
        idle();

        // PC register is never tracked
        issue(4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1 chk("pc_dest_acc", accept, 1'b1);
        tick();
        chk("pc_busy", busy_mask, 16'h0000);
        issue(4'd0, 1'b0, 4'd15, 1'b1, 4'd15, 1'b1);
        #1 chk("pc_read_stall", stall, 1'b0);
        tick();
        idle();

        // Flush clears r1/r4; stale writeback then ignored
        issue(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        issue(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("fl_busy", busy_mask, 16'h0012);
        issue(4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        flush = 1'b1;
        #1 chk("fl_acc_forced0", accept, 1'b0);
        tick();
        idle();
        chk("fl_busy_clr", busy_mask, 16'h0000);
        wb(4'd1);
        tick();
        idle();
        chk("fl_stale_wb", busy_mask, 16'h0000);
        issue(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        idle();
        chk("fl_reissue_busy", busy_mask, 16'h0002);
        wb(4'd1);
        tick();
        idle();
        chk("fl_no_underflow", busy_mask, 16'h0000);

        // Drain handshake with r5 pending
        issue(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        idle();
        drain_req = 1'b1;
        tick();
        issue(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1 chk("dr_stall", stall, 1'b1);
        chk("dr_not_done", drained, 1'b0);
        tick();
        idle();
        wb(4'd5);
        tick();
        idle();
        chk("dr_drained", drained, 1'b1);
        chk("dr_busy", busy_mask, 16'h0000);
        issue(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1 chk("dr_done_stall", stall, 1'b1);
        drain_req = 1'b0;
        tick();
        chk("dr_released", drained, 1'b0);
        #1 chk("dr_resume_acc", accept, 1'b1);
        tick();
        idle();
        chk("dr_busy7", busy_mask, 16'h0080);
        wb(4'd7);
        tick();
        idle();

        // Asynchronous reset in the middle of a drain
        issue(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        idle();
        drain_req = 1'b1;
        tick();
        chk("ar_busy_pre", busy_mask, 16'h0200);
        drain_req = 1'b0;
        reset_n = 1'b0;
        issue(4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0);
        #1 chk("ar_busy", busy_mask, 16'h0000);
        chk("ar_drained", drained, 1'b0);
        chk("ar_state_run", stall, 1'b0);
        #1 reset_n = 1'b1;
        tick();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
